// File: rtl/ledgame_pkg.sv
// Shared definitions for the LED game blocks: channel mode codes and a
// counter-width helper used to size the debounce and blink counters.
package ledgame_pkg;

  localparam logic [1:0] MODE_TOGGLE    = 2'b00;
  localparam logic [1:0] MODE_MOMENTARY = 2'b01;
  localparam logic [1:0] MODE_BLINK     = 2'b10;
  localparam logic [1:0] MODE_OFF       = 2'b11;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/toggle_led_chan.sv
// One button->LED channel: 2-FF synchroniser, debouncer, rising-edge detect,
// toggle state and the registered mode mux gated by the shared blink/PWM enables.
module toggle_led_chan
  import ledgame_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] mode,
  input  logic       blink_phase,
  input  logic       pwm_on,
  output logic       value,
  output logic       press
);

  localparam int            CW      = clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic          deb_d_r;
  logic [CW-1:0] cnt_r;
  logic          state_r;
  logic          value_r;
  logic          press_r;
  logic          rise_s;
  logic          state_nx_s;
  logic          mode_val_s;

  // synchroniser and debouncer; the count restarts whenever the input agrees again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      deb_d_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      if (sync2_r == deb_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        deb_r <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // next toggle state and mode-selected LED level; new state is visible the same edge
  always_comb begin
    rise_s     = deb_r & ~deb_d_r;
    state_nx_s = state_r ^ rise_s;
    case (mode)
      MODE_TOGGLE:    mode_val_s = state_nx_s;
      MODE_MOMENTARY: mode_val_s = deb_r;
      MODE_BLINK:     mode_val_s = state_nx_s & blink_phase;
      MODE_OFF:       mode_val_s = 1'b0;
      default:        mode_val_s = 1'b0;
    endcase
  end

  // registered toggle state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= 1'b0;
      value_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      value_r <= mode_val_s & pwm_on;
      press_r <= rise_s;
    end
  end

  assign value = value_r;
  assign press = press_r;

endmodule

// File: rtl/toggle_led_bank.sv
// NUM_CH independent debounced button->LED channels sharing one blink timebase.
// Optional per-channel PWM dimming is built when TOGGLE_LED_PWM_EN is defined.
module toggle_led_bank
  import ledgame_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int BLINK_HALF   = 50,
  parameter int PWM_BITS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          btn,
  input  logic [2*NUM_CH-1:0]        mode,
  input  logic [PWM_BITS*NUM_CH-1:0] brightness,
  output logic [NUM_CH-1:0]          value,
  output logic [NUM_CH-1:0]          press
);

  localparam int            BW       = clog2(BLINK_HALF);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);

  logic [BW-1:0]     bcnt_r;
  logic              blink_phase_r;
  logic [NUM_CH-1:0] pwm_on_s;

  // free-running blink timebase, never restarted by mode changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_r        <= '0;
      blink_phase_r <= 1'b0;
    end else if (bcnt_r == BCNT_MAX) begin
      bcnt_r        <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      bcnt_r        <= bcnt_r + BCNT_ONE;
    end
  end

`ifdef TOGGLE_LED_PWM_EN
  localparam logic [PWM_BITS-1:0] PCNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pcnt_r;

  // shared PWM ramp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r <= '0;
    end else begin
      pcnt_r <= pcnt_r + PCNT_ONE;
    end
  end

  // per-channel duty compare
  always_comb begin
    pwm_on_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_on_s[i] = (pcnt_r < brightness[PWM_BITS*i +: PWM_BITS]);
    end
  end
`else
  logic unused_brightness_s;

  assign unused_brightness_s = ^brightness;
  assign pwm_on_s            = '1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    toggle_led_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn[g]),
      .mode       (mode[2*g +: 2]),
      .blink_phase(blink_phase_r),
      .pwm_on     (pwm_on_s[g]),
      .value      (value[g]),
      .press      (press[g])
    );
  end

endmodule

// File: tb/tb_toggle_led_bank.sv
// Self-checking bench for toggle_led_bank: directed vector table, hand-written
// reset/blink sequences and randomized traffic against a history-based model.
module tb_toggle_led_bank;

  localparam int NUM_CH       = 4;
  localparam int DEBOUNCE_CYC = 4;
  localparam int BLINK_HALF   = 5;
  localparam int PWM_BITS     = 4;

  logic                       clk;
  logic                       rst;
  logic [NUM_CH-1:0]          btn;
  logic [2*NUM_CH-1:0]        mode;
  logic [PWM_BITS*NUM_CH-1:0] brightness;
  logic [NUM_CH-1:0]          value;
  logic [NUM_CH-1:0]          press;

  int tests_run;
  int tests_failed;

  toggle_led_bank #(
    .NUM_CH      (NUM_CH),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .BLINK_HALF  (BLINK_HALF),
    .PWM_BITS    (PWM_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .mode      (mode),
    .brightness(brightness),
    .value     (value),
    .press     (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges counted since reset release, raw button samples per edge.
  int                n_edge;
  logic [NUM_CH-1:0] bq[$];
  logic [NUM_CH-1:0] deb_m;
  logic [NUM_CH-1:0] state_m;
  logic [NUM_CH-1:0] rose_m;
  logic [NUM_CH-1:0] exp_value;
  logic [NUM_CH-1:0] exp_press;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    bq.delete();
    deb_m     = '0;
    state_m   = '0;
    rose_m    = '0;
    exp_value = '0;
    exp_press = '0;
  endtask

  // Synchronised level seen by the debouncer at edge m: the button two edges earlier.
  function automatic logic s2_obs(input int m, input int c);
    if (m >= 3) return bq[m-3][c];
    return 1'b0;
  endfunction

  task automatic model_edge();
    int   phase;
    int   pcnt;
    logic v;
    logic all_diff;
    n_edge++;
    bq.push_back(btn);
    phase = ((n_edge - 1) / BLINK_HALF) % 2;
    pcnt  = (n_edge - 1) % (1 << PWM_BITS);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rose_m[c]) state_m[c] = ~state_m[c];
      exp_press[c] = rose_m[c];
      case (mode[2*c +: 2])
        2'b00:   v = state_m[c];
        2'b01:   v = deb_m[c];
        2'b10:   v = state_m[c] & (phase == 1);
        default: v = 1'b0;
      endcase
`ifdef TOGGLE_LED_PWM_EN
      if (pcnt >= int'(brightness[PWM_BITS*c +: PWM_BITS])) v = 1'b0;
`endif
      exp_value[c] = v;
      // accepted once the last DEBOUNCE_CYC observations all disagree with the debounced level
      rose_m[c] = 1'b0;
      if (n_edge >= DEBOUNCE_CYC) begin
        all_diff = 1'b1;
        for (int m = n_edge - DEBOUNCE_CYC + 1; m <= n_edge; m++) begin
          if (s2_obs(m, c) == deb_m[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          deb_m[c]  = ~deb_m[c];
          rose_m[c] = deb_m[c];
        end
      end
    end
  endtask

  // One clock: model the edge, compare just after it, return at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check("value", value, exp_value);
    check("press", press, exp_press);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_value", value, '0);
    check("rst_press", press, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NUM_CH-1:0]   btn;
    logic [2*NUM_CH-1:0] mode;
    int                  hold;
    logic [NUM_CH-1:0]   exp_value;
  } vec_t;

  vec_t tbl[14];
  logic got_bits[30];
  int   hold_c[NUM_CH];
  int   t_first;
  int   bad;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    btn          = '0;
    mode         = '0;
    brightness   = '0;
    model_reset();
    @(negedge clk);
    do_reset();

`ifndef TOGGLE_LED_PWM_EN
    // brightness stays 0 here: without PWM it must have no effect
    tbl[0]  = '{4'b0001, 8'h00, 10, 4'b0001};
    tbl[1]  = '{4'b0000, 8'h00, 10, 4'b0001};
    tbl[2]  = '{4'b0001, 8'h00, 10, 4'b0000};
    tbl[3]  = '{4'b0000, 8'h00, 10, 4'b0000};
    tbl[4]  = '{4'b1010, 8'h00, 10, 4'b1010};
    tbl[5]  = '{4'b0010, 8'h00, 10, 4'b1010};
    tbl[6]  = '{4'b0000, 8'h00, 10, 4'b1010};
    tbl[7]  = '{4'b1111, 8'h55, 10, 4'b1111};
    tbl[8]  = '{4'b1111, 8'hFF,  3, 4'b0000};
    tbl[9]  = '{4'b0000, 8'h00, 10, 4'b0101};
    tbl[10] = '{4'b0101, 8'h00,  3, 4'b0101};
    tbl[11] = '{4'b0000, 8'h00, 10, 4'b0101};
    tbl[12] = '{4'b0001, 8'h00,  6, 4'b0101};
    tbl[13] = '{4'b0000, 8'h00, 10, 4'b0100};
    for (int i = 0; i < 14; i++) begin
      btn  = tbl[i].btn;
      mode = tbl[i].mode;
      for (int k = 0; k < tbl[i].hold; k++) step();
      check($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
      check($sformatf("tbl%0d_press", i), press, '0);
    end
`endif

    // button held through reset release: press exactly at the 7th edge
    btn  = 4'b0001;
    mode = 8'h00;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("rel_press_e%0d", k), press[0], (k == 7) ? 1 : 0);
    end
    check("rel_value", value[0], 1);

    // blink on ch0 with toggle state set: 5 on / 5 off
    mode = 8'h02;
    for (int i = 0; i < 30; i++) begin
      step();
      got_bits[i] = value[0];
    end
    t_first = -1;
    for (int i = 1; i < 12; i++) begin
      if (t_first < 0 && got_bits[i] != got_bits[i-1]) t_first = i;
    end
    check("blink_edge_found", (t_first >= 0) ? 1 : 0, 1);
    if (t_first >= 0) begin
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        if (got_bits[t_first+i] != got_bits[t_first]) bad++;
        if (got_bits[t_first+5+i] == got_bits[t_first]) bad++;
      end
      check("blink_period", bad, 0);
    end

    // randomized traffic
    for (int c = 0; c < NUM_CH; c++) hold_c[c] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hold_c[c] == 0) begin
          btn[c]    = 1'($urandom_range(0, 1));
          hold_c[c] = $urandom_range(1, 14);
        end else begin
          hold_c[c]--;
        end
      end
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 39) == 0) brightness = 16'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
